// File: rtl/lcd_frame_writer_if.sv
// BRAM read-port bundle between the character buffer and lcd_frame_writer.
interface lcd_frame_writer_if;
    logic [11:0] ADDR;
    logic        EN;
    logic        WE;
    logic [3:0]  DO;

    modport master (output ADDR, output EN, output WE, input DO);
    modport slave  (input ADDR, input EN, input WE, output DO);
endinterface

// File: rtl/lcd_frame_writer.sv
// HD44780 4-bit initialiser and continuous two-line refresher fed from the
// 4k x 4 character BRAM (low nibble at 2c, high nibble at 2c+1).
module lcd_frame_writer #(
    parameter int T_PWR      = 750000,
    parameter int T_INIT1    = 205000,
    parameter int T_INIT2    = 5000,
    parameter int T_SETUP    = 2,
    parameter int T_EN       = 12,
    parameter int T_HOLD     = 1,
    parameter int T_NIB      = 50,
    parameter int T_CMD      = 2000,
    parameter int T_CLR      = 82000,
    parameter int LINE2_CHAR = 40
) (
    input  logic               clk,
    input  logic               reset,
    lcd_frame_writer_if.master bram,
    output logic               lcd_e,
    output logic               lcd_rs,
    output logic               lcd_rw,
    output logic [3:0]         lcd_d,
    output logic               init_done,
    output logic               frame_done
);

    function automatic int max_wait();
        int m;
        m = T_PWR;
        if (T_INIT1 > m) m = T_INIT1;
        if (T_INIT2 > m) m = T_INIT2;
        if (T_CLR > m)   m = T_CLR;
        if (T_CMD > m)   m = T_CMD;
        if (T_NIB > m)   m = T_NIB;
        if (T_EN > m)    m = T_EN;
        if (T_SETUP > m) m = T_SETUP;
        if (T_HOLD > m)  m = T_HOLD;
        return m;
    endfunction

    localparam int CNT_W = $clog2(max_wait() + 1);

    function automatic logic [7:0] cfg_byte(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h28;
            2'd1:    return 8'h06;
            2'd2:    return 8'h0C;
            default: return 8'h01;
        endcase
    endfunction

    typedef enum logic [1:0] {PWR_WAIT, INIT, CONFIG, REFRESH} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_HOLD, PH_GAP} phase_t;

    state_t             state, state_nxt;
    phase_t             phase, phase_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         idx, idx_nxt;
    logic               lo, lo_nxt;
    logic               line, line_nxt;
    logic [4:0]         pos, pos_nxt;
    logic [3:0]         d_nxt;
    logic               rs_nxt;
    logic               done_nxt;
    logic               frame_nxt;
    logic               en_nxt;
    logic [11:0]        addr_nxt;
    logic [7:0]         cfg_cur, cfg_next;
    int                 gap_len;
    logic               fetch_req;
    logic [10:0]        char_base, fetch_char;
    logic [11:0]        fetch_addr;

    assign lcd_rw  = 1'b0;
    assign bram.WE = 1'b0;

    assign cfg_cur  = cfg_byte(idx);
    assign cfg_next = cfg_byte(idx + 2'd1);

    // Gap following the nibble that just finished, chosen by its position.
    always_comb begin
        gap_len = T_CMD;
        case (state)
            INIT: begin
                if (idx == 2'd0)      gap_len = T_INIT1;
                else if (idx == 2'd1) gap_len = T_INIT2;
            end
            CONFIG: begin
                if (!lo)              gap_len = T_NIB;
                else if (idx == 2'd3) gap_len = T_CLR;
            end
            REFRESH: begin
                if (!lo)              gap_len = T_NIB;
            end
            default: gap_len = T_CMD;
        endcase
    end

    // Next data nibble to fetch: low half of the current char, or high half of the next one.
    assign char_base  = line ? 11'(LINE2_CHAR) : 11'd0;
    assign fetch_char = char_base + {6'd0, pos} - {10'd0, ~lo};
    assign fetch_addr = {fetch_char, lo};
    assign fetch_req  = (state == REFRESH) && ((!lo && pos != 5'd0) || (lo && pos != 5'd16));

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        lo_nxt    = lo;
        line_nxt  = line;
        pos_nxt   = pos;
        d_nxt     = lcd_d;
        rs_nxt    = lcd_rs;
        done_nxt  = init_done;
        frame_nxt = 1'b0;
        en_nxt    = 1'b0;
        addr_nxt  = bram.ADDR;

        if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end else begin
            case (phase)
                PH_SETUP: begin
                    phase_nxt = PH_STROBE;
                    cnt_nxt   = CNT_W'(T_EN - 1);
                end
                PH_STROBE: begin
                    phase_nxt = PH_HOLD;
                    cnt_nxt   = CNT_W'(T_HOLD - 1);
                end
                PH_HOLD: begin
                    phase_nxt = PH_GAP;
                    cnt_nxt   = CNT_W'(gap_len - 1);
                end
                default: begin
                    // End of a gap (or of the power-on wait): present the next nibble.
                    phase_nxt = PH_SETUP;
                    cnt_nxt   = CNT_W'(T_SETUP - 1);
                    case (state)
                        PWR_WAIT: begin
                            state_nxt = INIT;
                            idx_nxt   = 2'd0;
                            d_nxt     = 4'h3;
                            rs_nxt    = 1'b0;
                        end
                        INIT: begin
                            if (idx != 2'd3) begin
                                idx_nxt = idx + 2'd1;
                                d_nxt   = (idx == 2'd2) ? 4'h2 : 4'h3;
                            end else begin
                                state_nxt = CONFIG;
                                idx_nxt   = 2'd0;
                                lo_nxt    = 1'b0;
                                d_nxt     = cfg_byte(2'd0) >> 4;
                            end
                        end
                        CONFIG: begin
                            if (!lo) begin
                                lo_nxt = 1'b1;
                                d_nxt  = cfg_cur[3:0];
                            end else if (idx != 2'd3) begin
                                idx_nxt = idx + 2'd1;
                                lo_nxt  = 1'b0;
                                d_nxt   = cfg_next[7:4];
                            end else begin
                                state_nxt = REFRESH;
                                done_nxt  = 1'b1;
                                line_nxt  = 1'b0;
                                pos_nxt   = 5'd0;
                                lo_nxt    = 1'b0;
                                d_nxt     = 4'h8;
                            end
                        end
                        default: begin
                            if (!lo) begin
                                lo_nxt = 1'b1;
                                rs_nxt = (pos != 5'd0);
                                d_nxt  = (pos == 5'd0) ? 4'h0 : bram.DO;
                            end else if (pos != 5'd16) begin
                                pos_nxt = pos + 5'd1;
                                lo_nxt  = 1'b0;
                                rs_nxt  = 1'b1;
                                d_nxt   = bram.DO;
                            end else begin
                                pos_nxt = 5'd0;
                                lo_nxt  = 1'b0;
                                rs_nxt  = 1'b0;
                                if (!line) begin
                                    line_nxt = 1'b1;
                                    d_nxt    = 4'hC;
                                end else begin
                                    line_nxt  = 1'b0;
                                    d_nxt     = 4'h8;
                                    frame_nxt = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            endcase
        end

        // Read one cycle before the gap ends so DO is valid when the nibble is latched.
        if (phase_nxt == PH_GAP && cnt_nxt == CNT_W'(1) && fetch_req) begin
            en_nxt   = 1'b1;
            addr_nxt = fetch_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PWR_WAIT;
            phase      <= PH_GAP;
            cnt        <= CNT_W'(T_PWR - 1);
            idx        <= 2'd0;
            lo         <= 1'b0;
            line       <= 1'b0;
            pos        <= 5'd0;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_d      <= 4'h0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            bram.ADDR  <= 12'd0;
            bram.EN    <= 1'b0;
        end else begin
            state      <= state_nxt;
            phase      <= phase_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            lo         <= lo_nxt;
            line       <= line_nxt;
            pos        <= pos_nxt;
            lcd_e      <= (phase_nxt == PH_STROBE);
            lcd_rs     <= rs_nxt;
            lcd_d      <= d_nxt;
            init_done  <= done_nxt;
            frame_done <= frame_nxt;
            bram.ADDR  <= addr_nxt;
            bram.EN    <= en_nxt;
        end
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer with shrunk timing and a 1-cycle BRAM model.
module tb_lcd_frame_writer;

    localparam int T_PWR = 20, T_INIT1 = 10, T_INIT2 = 5, T_CMD = 8, T_CLR = 12, T_NIB = 3;
    localparam int T_SETUP = 2, T_EN = 12, T_HOLD = 1, LINE2_CHAR = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [3:0] lcd_d;

    lcd_frame_writer_if bram();

    lcd_frame_writer #(
        .T_PWR(T_PWR), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_SETUP(T_SETUP),
        .T_EN(T_EN), .T_HOLD(T_HOLD), .T_NIB(T_NIB), .T_CMD(T_CMD),
        .T_CLR(T_CLR), .LINE2_CHAR(LINE2_CHAR)
    ) dut (
        .clk(clk), .reset(reset), .bram(bram),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_d(lcd_d),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [4096];
    always @(posedge clk) if (bram.EN) bram.DO <= mem[bram.ADDR];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor state
    int         cyc = 0, scount = 0, acount = 0, fcount = 0;
    int         run = 0, hi_cnt = 0, sh_bad = 0, width_bad = 0, en_bad = 0, we_bad = 0;
    int         done_cyc = 0, frame_cyc = 0;
    logic       prev_e = 1'b0, prev_en = 1'b0, prev_done = 1'b0;
    logic [4:0] prev_rsd = 5'd0;
    logic [4:0] s_nib [256];
    int         s_fall [256];
    int         a_q [256];

    initial begin
        forever begin
            @(negedge clk);
            if (bram.WE || lcd_rw) we_bad++;
            if (reset) begin
                prev_e = 1'b0; prev_en = 1'b0; prev_done = 1'b0; hi_cnt = 0; run = 0;
            end else begin
                cyc++;
                if ({lcd_rs, lcd_d} == prev_rsd) run++; else run = 1;
                prev_rsd = {lcd_rs, lcd_d};
                if (lcd_e && !prev_e) begin
                    if (run < T_SETUP + 1) sh_bad++;
                    if (scount < 256) s_nib[scount] = {lcd_rs, lcd_d};
                    scount++;
                    hi_cnt = 0;
                end
                if (lcd_e) hi_cnt++;
                if (!lcd_e && prev_e) begin
                    if (hi_cnt != T_EN) width_bad++;
                    if (run < T_SETUP + T_EN + T_HOLD) sh_bad++;
                    if (scount >= 1 && scount <= 256) s_fall[scount-1] = cyc;
                end
                prev_e = lcd_e;
                if (bram.EN) begin
                    if (prev_en) en_bad++;
                    if (acount < 256) a_q[acount] = int'(bram.ADDR);
                    acount++;
                end
                prev_en = bram.EN;
                if (init_done && !prev_done) done_cyc = cyc;
                prev_done = init_done;
                if (frame_done) begin
                    fcount++;
                    frame_cyc = cyc;
                end
            end
        end
    end

    function automatic int outs();
        return int'({lcd_e, lcd_rs, lcd_rw, lcd_d, bram.ADDR, bram.EN, bram.WE, init_done, frame_done});
    endfunction

    // Expected {rs, nibble} of strobe k counted from the first init nibble.
    function automatic int exp_strobe(input int k);
        logic [7:0] b;
        logic       rs;
        int         j, n;
        case (k)
            0, 1, 2: return 3;
            3, 4:    return 2;
            5:       return 8;
            6, 8, 10: return 0;
            7:       return 6;
            9:       return 12;
            11:      return 1;
            default: ;
        endcase
        j = (k - 12) % 68;
        n = j / 2;
        if (n == 0) begin
            b = 8'h80; rs = 1'b0;
        end else if (n <= 16) begin
            b = 8'(8'h40 + n); rs = 1'b1;
        end else if (n == 17) begin
            b = 8'hC0; rs = 1'b0;
        end else begin
            b = (n - 18 < 15) ? 8'(8'h61 + n - 18) : 8'h7C; rs = 1'b1;
        end
        return int'({rs, (j % 2 == 0) ? b[7:4] : b[3:0]});
    endfunction

    function automatic int exp_addr(input int i);
        int c, w;
        w = i % 32;
        c = ((i / 32) == 1 ? LINE2_CHAR : 0) + w / 2;
        return 2 * c + ((w % 2 == 0) ? 1 : 0);
    endfunction

    task automatic wait_strobes(input int n);
        int budget;
        budget = 6000;
        while (scount < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (scount < n) check($sformatf("timeout_strobes_%0d", n), scount, n);
    endtask

    int acc;
    int base;
    logic [7:0] v;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
        for (int c = 0; c < 16; c++) begin
            v = 8'(8'h41 + c);
            mem[2*c] = v[3:0]; mem[2*c+1] = v[7:4];
            v = (c < 15) ? 8'(8'h61 + c) : 8'h7C;
            mem[2*(LINE2_CHAR+c)] = v[3:0]; mem[2*(LINE2_CHAR+c)+1] = v[7:4];
        end

        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", outs(), 0);
        reset = 1'b0;

        acc = 0;
        repeat (19) begin
            @(negedge clk);
            acc |= outs();
        end
        check("pwr_quiet", acc, 0);
        @(negedge clk);
        check("pwr_first_setup", int'({lcd_e, lcd_rs, lcd_d}), 3);
        repeat (2) @(negedge clk);
        check("first_e_rise", int'(lcd_e), 1);

        wait_strobes(12);
        for (int k = 0; k < 12; k++) check($sformatf("init_strobe_%0d", k), int'(s_nib[k]), exp_strobe(k));

        wait_strobes(82);
        check("init_done_latency", done_cyc - s_fall[11], T_HOLD + T_CLR);
        for (int k = 12; k < 82; k++) check($sformatf("frame_strobe_%0d", k), int'(s_nib[k]), exp_strobe(k));
        for (int i = 0; i < 64; i++) check($sformatf("fetch_addr_%0d", i), a_q[i], exp_addr(i));
        check("frame_done_count", fcount, 1);
        check("frame_done_latency", frame_cyc - s_fall[79], T_HOLD + T_CMD);
        check("en_single_cycle", en_bad, 0);

        // Reset while E is high in the middle of line 2 of the second frame.
        wait_strobes(120);
        @(posedge clk);
        #3;
        check("e_high_before_reset", int'({lcd_e, init_done}), 3);
        reset = 1'b1;
        #1;
        check("async_reset_drop", int'({lcd_e, init_done, bram.EN}), 0);
        repeat (3) @(negedge clk);
        check("reset_hold_outputs", outs(), 0);
        base = scount;
        reset = 1'b0;
        @(negedge clk);
        check("init_done_low_after_release", int'(init_done), 0);

        wait_strobes(base + 13);
        for (int k = 0; k < 12; k++)
            check($sformatf("replay_strobe_%0d", k), int'(s_nib[base+k]), exp_strobe(k));
        check("replay_init_done_latency", done_cyc - s_fall[base+11], T_HOLD + T_CLR);
        check("setup_hold_stable", sh_bad, 0);
        check("e_width", width_bad, 0);
        check("we_rw_never_high", we_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
